bit_seq: RTL and testbench

- Serial bit-pattern sequencer. Steps through the bits of a DEPTH-wide pattern word one bit at a time, LSB first, and drives the selected bit on a single-bit output. Wraps endlessly.
- The step rate is set by a programmable clock divider: one step every `len` enabled clock cycles.
- Used as a rhythmic/gate pattern source in the synthesis fabric; the output feeds downstream triggers and modulators.

---
 rtl/bit_seq.sv | 47 ++++
 tb/tb_bit_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bit_seq.sv
// rtl/bit_seq.sv - serial bit-pattern sequencer with programmable step divider
// Emits data_in bits LSB first, one step every len enabled cycles, wrapping forever.
module bit_seq #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DEPTH-1:0] data_in,
  input  logic [23:0]      len,
  output logic             data_out
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  // Declaration initializers match reset so the block runs with rst tied low.
  logic [23:0]   div   = '0;
  logic [IW-1:0] idx   = '0;
  logic          out_q = 1'b0;

  logic [23:0] lim;
  logic        step;

  // len==0 behaves as len==1; >= lets a shrinking len step immediately.
  assign lim  = (len == 24'd0) ? 24'd0 : len - 24'd1;
  assign step = (div >= lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      idx   <= '0;
      out_q <= 1'b0;
    end else if (ena) begin
      if (step) begin
        div   <= '0;
        out_q <= data_in[idx];
        idx   <= (idx == LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 24'd1;
      end
    end
  end

  assign data_out = out_q;

endmodule

// File: tb/tb_bit_seq.sv
// tb/tb_bit_seq.sv - scoreboard bench for bit_seq (DEPTH=9)
// Driver pushes expected data_out per edge; monitor pops and compares on negedge.
module tb_bit_seq;

  localparam int DEPTH = 9;

  logic             clk;
  logic             rst;
  logic             ena;
  logic [DEPTH-1:0] data_in;
  logic [23:0]      len;
  logic             data_out;

  typedef struct {
    logic  exp;
    string tag;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  // Hand-written emission order of 9'b100011001, LSB first.
  bit pat [DEPTH] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  bit_seq #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .data_in  (data_in),
    .len      (len),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output after the n-th enabled edge since reset, period p.
  function automatic logic exp_at(input int n, input int p);
    if (n < p) return 1'b0;
    return pat[((n - p) / p) % DEPTH];
  endfunction

  task automatic drive(input logic e, input logic r, input logic x, input string tag);
    sb_item_t it;
    ena = e;
    rst = r;
    @(posedge clk);
    #1;
    it.exp = x;
    it.tag = tag;
    sb.push_back(it);
  endtask

  // Monitor: one comparison per pushed expectation, sampled mid-cycle.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (data_out !== it.exp) begin
          errors++;
          $display("FAIL %s: data_out=%0b expected=%0b", it.tag, data_out, it.exp);
        end
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b0;
    ena     = 1'b0;
    len     = 24'd3;
    data_in = 9'b100011001;

    // Power-up state with rst never asserted
    drive(1'b0, 1'b0, 1'b0, "powerup");

    // Case 1: len=3 from power-up, two full pattern periods
    for (n = 1; n <= 56; n++) drive(1'b1, 1'b0, exp_at(n, 3), "len3_run");

    // Case 2: len=1, one bit per cycle including wrap 8->0
    len = 24'd1;
    drive(1'b1, 1'b1, 1'b0, "rst_len1");
    for (n = 1; n <= 20; n++) drive(1'b1, 1'b0, exp_at(n, 1), "len1_run");

    // Case 3: len=0 must match len=1 stream
    len = 24'd0;
    drive(1'b1, 1'b1, 1'b0, "rst_len0");
    for (n = 1; n <= 20; n++) drive(1'b1, 1'b0, exp_at(n, 1), "len0_run");

    // Case 4: ena gap of 5 cycles mid-step, no phase loss
    len = 24'd3;
    drive(1'b1, 1'b1, 1'b0, "rst_ena");
    for (n = 1; n <= 4; n++) drive(1'b1, 1'b0, exp_at(n, 3), "ena_pre");
    for (int g = 0; g < 5; g++) drive(1'b0, 1'b0, 1'b1, "ena_frozen");
    for (n = 5; n <= 35; n++) drive(1'b1, 1'b0, exp_at(n, 3), "ena_post");

    // Case 5: shrink len 10->2 at div=7, then edit data_in ahead of its step
    len = 24'd10;
    drive(1'b1, 1'b1, 1'b0, "rst_mid");
    for (n = 1; n <= 7; n++) drive(1'b1, 1'b0, 1'b0, "len10_wait");
    len = 24'd2;
    drive(1'b1, 1'b0, 1'b1, "shrink_step");
    data_in = 9'b100011011;
    drive(1'b1, 1'b0, 1'b1, "len2_hold");
    drive(1'b1, 1'b0, 1'b1, "new_bit1");
    drive(1'b1, 1'b0, 1'b1, "len2_hold");
    drive(1'b1, 1'b0, 1'b0, "bit2");
    data_in = 9'b100010011;
    drive(1'b1, 1'b0, 1'b0, "len2_hold");
    drive(1'b1, 1'b0, 1'b0, "new_bit3");
    drive(1'b1, 1'b0, 1'b0, "len2_hold");
    drive(1'b1, 1'b0, 1'b1, "bit4");

    // Case 6: rst at idx=5, restart after P; rst with ena=0
    data_in = 9'b100011001;
    len = 24'd3;
    drive(1'b1, 1'b1, 1'b0, "rst_pre6");
    for (n = 1; n <= 16; n++) drive(1'b1, 1'b0, exp_at(n, 3), "pre_rst_run");
    drive(1'b1, 1'b1, 1'b0, "rst_idx5");
    for (n = 1; n <= 7; n++) drive(1'b1, 1'b0, exp_at(n, 3), "post_rst_run");
    drive(1'b0, 1'b1, 1'b0, "rst_no_ena");
    for (n = 1; n <= 4; n++) drive(1'b1, 1'b0, exp_at(n, 3), "post_rst0_run");

    // Drain: the monitor must consume every expectation within a cycle
    ena = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
